// File: rtl/mult_sched_pkg.sv
// Shared definitions for mult_scheduler: FSM state codes, index sizing and
// saturation limits derived from the operand width.
package mult_sched_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Drain counter only has to reach MULT_STAGES-1 (at most 2).
  localparam int DRAIN_W = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint sat_max(input int bits);
    return (64'sd1 <<< (bits - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(64'sd1 <<< (bits - 1));
  endfunction

endpackage

// File: rtl/mult_scheduler_shared_mult.sv
// Pipelined signed Q1.(BITSIZE-1) multiplier carrying a channel tag.
// Define MULT_SCHEDULER_ROUND_EN to round half-up instead of truncating.
module shared_mult
  import mult_sched_pkg::*;
#(
  parameter int BITSIZE     = 16,
  parameter int MULT_STAGES = 2,
  parameter int TAG_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic                      out_valid,
  output logic [TAG_W-1:0]          out_tag,
  output logic signed [BITSIZE-1:0] result
);

  localparam int PW = 2 * BITSIZE;
  localparam logic signed [PW:0] SAT_HI = (PW + 1)'(sat_max(BITSIZE));
  localparam logic signed [PW:0] SAT_LO = (PW + 1)'(sat_min(BITSIZE));
`ifdef MULT_SCHEDULER_ROUND_EN
  localparam logic signed [PW:0] BIAS = (PW + 1)'(64'sd1 <<< (BITSIZE - 2));
`else
  localparam logic signed [PW:0] BIAS = '0;
`endif

  logic signed [PW-1:0]   prod_pipe [MULT_STAGES];
  logic [TAG_W-1:0]       tag_pipe  [MULT_STAGES];
  logic [MULT_STAGES-1:0] valid_pipe;
  logic signed [PW:0]     biased;
  logic signed [PW:0]     scaled;

  // Raw product enters stage 0 so the multiply maps onto a registered DSP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pipe <= '0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        prod_pipe[i] <= '0;
        tag_pipe[i]  <= '0;
      end
    end else begin
      valid_pipe[0] <= in_valid;
      tag_pipe[0]   <= in_tag;
      prod_pipe[0]  <= $signed({{BITSIZE{a[BITSIZE-1]}}, a}) *
                       $signed({{BITSIZE{b[BITSIZE-1]}}, b});
      for (int i = 1; i < MULT_STAGES; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        tag_pipe[i]   <= tag_pipe[i-1];
        prod_pipe[i]  <= prod_pipe[i-1];
      end
    end
  end

  // One extra bit keeps the bias add from wrapping before saturation.
  always_comb begin
    biased = {prod_pipe[MULT_STAGES-1][PW-1], prod_pipe[MULT_STAGES-1]} + BIAS;
    scaled = biased >>> (BITSIZE - 1);
    if (scaled > SAT_HI)
      result = SAT_HI[BITSIZE-1:0];
    else if (scaled < SAT_LO)
      result = SAT_LO[BITSIZE-1:0];
    else
      result = scaled[BITSIZE-1:0];
  end

  assign out_valid = valid_pipe[MULT_STAGES-1];
  assign out_tag   = tag_pipe[MULT_STAGES-1];

endmodule

// File: rtl/mult_scheduler.sv
// Once per LR-clock frame, runs all channel operand pairs through one shared
// multiplier and presents the results together. Rounding: MULT_SCHEDULER_ROUND_EN.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int BITSIZE     = 16,
  parameter int CHANNELS    = 4,
  parameter int MULT_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lrclk,
  input  logic [CHANNELS-1:0]           enable,
  input  logic [CHANNELS*BITSIZE-1:0]   in1,
  input  logic [CHANNELS*BITSIZE-1:0]   in2,
  output logic [CHANNELS*BITSIZE-1:0]   out,
  output logic                          valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int KW = idx_width(CHANNELS);
  localparam logic [KW-1:0]      LAST_K = KW'(CHANNELS - 1);
  localparam logic [DRAIN_W-1:0] LAST_D = DRAIN_W'(MULT_STAGES - 1);

  logic                      sync1, sync2, sync3, trig;
  logic [2:0]                state;
  logic [KW-1:0]             k;
  logic [DRAIN_W-1:0]        d_cnt;
  logic [CHANNELS-1:0]       en_snap;
  logic signed [BITSIZE-1:0] a_snap      [CHANNELS];
  logic signed [BITSIZE-1:0] b_snap      [CHANNELS];
  logic signed [BITSIZE-1:0] shadow      [CHANNELS];
  logic signed [BITSIZE-1:0] shadow_next [CHANNELS];
  logic                      res_valid;
  logic [KW-1:0]             res_tag;
  logic signed [BITSIZE-1:0] res;

  // Sync flops reset high so a level already high at reset release is no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
      trig  <= 1'b0;
    end else begin
      sync1 <= lrclk;
      sync2 <= sync1;
      sync3 <= sync2;
      trig  <= sync2 & ~sync3;
    end
  end

  shared_mult #(
    .BITSIZE     (BITSIZE),
    .MULT_STAGES (MULT_STAGES),
    .TAG_W       (KW)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state == ISSUE),
    .in_tag    (k),
    .a         (a_snap[k]),
    .b         (b_snap[k]),
    .out_valid (res_valid),
    .out_tag   (res_tag),
    .result    (res)
  );

  always_comb begin
    shadow_next = shadow;
    if (res_valid)
      shadow_next[res_tag] = en_snap[res_tag] ? res : '0;
  end

  assign busy = (state != IDLE);

  // out is loaded from shadow_next so the final product lands in the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      d_cnt   <= '0;
      en_snap <= '0;
      out     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        a_snap[i] <= '0;
        b_snap[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      valid  <= 1'b0;
      shadow <= shadow_next;
      if (trig && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: if (trig) state <= LOAD;
        LOAD: begin
          en_snap <= enable;
          for (int i = 0; i < CHANNELS; i++) begin
            a_snap[i] <= in1[i*BITSIZE +: BITSIZE];
            b_snap[i] <= in2[i*BITSIZE +: BITSIZE];
          end
          k     <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (k == LAST_K) begin
            d_cnt <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (d_cnt == LAST_D) begin
            for (int i = 0; i < CHANNELS; i++)
              out[i*BITSIZE +: BITSIZE] <= shadow_next[i];
            valid <= 1'b1;
            state <= DONE;
          end else begin
            d_cnt <= d_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed self-checking bench for mult_scheduler (CHANNELS=4, MULT_STAGES=2);
// rounding expectations follow MULT_SCHEDULER_ROUND_EN.
module tb_mult_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        lrclk;
  logic [3:0]  enable;
  logic [63:0] in1, in2, out;
  logic        valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_scheduler #(
    .BITSIZE     (16),
    .CHANNELS    (4),
    .MULT_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .lrclk   (lrclk),
    .enable  (enable),
    .in1     (in1),
    .in2     (in2),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  // lrclk rises before posedge n=1; cycle 0 is the one starting at posedge 3,
  // so valid (cycle 8) is seen after posedge 11 and busy after posedges 4..11.
  task automatic run_frame(input int second_rise, input logic change_in2,
                           input logic [63:0] late_in2,
                           output int vcnt, output int vcyc, output int bbad,
                           output logic [63:0] vout);
    vcnt = 0; vcyc = -1; bbad = 0; vout = '0;
    @(negedge clk);
    lrclk = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== ((n >= 4) && (n <= 11))) bbad++;
      if (valid === 1'b1) begin
        vcnt++;
        vcyc = n;
        vout = out;
      end
      if (n == 2) lrclk = 1'b0;
      if (second_rise > 0 && n == second_rise) lrclk = 1'b1;
      if (second_rise > 0 && n == second_rise + 2) lrclk = 1'b0;
      if (change_in2 && n == 6) in2 = late_in2;
    end
  endtask

  task automatic test_reset();
    int vseen, bseen;
    @(negedge clk);
    checks++;
    if (out !== 64'h0) begin errors++; $display("[TB] FAIL reset_out got %h want %h", out, 64'h0); end
    checks++;
    if ({valid, busy, overrun} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want %b", {valid, busy, overrun}, 3'b000);
    end
    // lrclk already high at release must not be taken as a frame edge
    lrclk = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vseen = 0; bseen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid === 1'b1) vseen++;
      if (busy === 1'b1) bseen++;
    end
    checks++;
    if (vseen + bseen !== 0) begin
      errors++; $display("[TB] FAIL no_false_trigger got %0d want %0d", vseen + bseen, 0);
    end
    lrclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int vcnt, vcyc, bbad;
    logic [63:0] vout;
    enable = 4'hF;
    in1 = {4{16'h4000}};
    in2 = {4{16'h4000}};
    run_frame(0, 1'b0, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vcyc !== 11) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", vcyc, 11); end
    checks++;
    if (vcnt !== 1) begin errors++; $display("[TB] FAIL basic_valid_count got %0d want %0d", vcnt, 1); end
    checks++;
    if (bbad !== 0) begin errors++; $display("[TB] FAIL basic_busy_window got %0d bad cycles want %0d", bbad, 0); end
    checks++;
    if (vout !== {4{16'h2000}}) begin
      errors++; $display("[TB] FAIL basic_out got %h want %h", vout, {4{16'h2000}});
    end
    in1 = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (out !== {4{16'h2000}} || valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_hold got %h/%b want %h/0", out, valid, {4{16'h2000}});
    end
  endtask

  task automatic test_saturation();
    int vcnt, vcyc, bbad;
    logic [63:0] vout;
    enable = 4'hF;
    in1 = {16'hC000, 16'h7FFF, 16'h7FFF, 16'h8000};
    in2 = {16'h4000, 16'h7FFF, 16'h8000, 16'h8000};
    run_frame(0, 1'b0, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vout !== {16'hE000, 16'h7FFE, 16'h8001, 16'h7FFF}) begin
      errors++; $display("[TB] FAIL saturation_out got %h want %h", vout, {16'hE000, 16'h7FFE, 16'h8001, 16'h7FFF});
    end
  endtask

  task automatic test_enable();
    int vcnt, vcyc, bbad;
    logic [63:0] vout;
    enable = 4'b1010;
    in1 = {4{16'h4000}};
    in2 = {4{16'h4000}};
    run_frame(0, 1'b0, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vcyc !== 11) begin errors++; $display("[TB] FAIL enable_latency got %0d want %0d", vcyc, 11); end
    checks++;
    if (vout !== {16'h2000, 16'h0000, 16'h2000, 16'h0000}) begin
      errors++; $display("[TB] FAIL enable_out got %h want %h", vout, {16'h2000, 16'h0000, 16'h2000, 16'h0000});
    end
  endtask

  task automatic test_rounding();
    int vcnt, vcyc, bbad;
    logic [63:0] vout, exp;
`ifdef MULT_SCHEDULER_ROUND_EN
    exp = {16'hFFFF, 16'h0800, 16'h0000, 16'h0001};
`else
    exp = {16'hFFFF, 16'h0800, 16'hFFFF, 16'h0000};
`endif
    enable = 4'hF;
    in1 = {16'h8000, 16'h2000, 16'hFFFF, 16'h0001};
    in2 = {16'h0001, 16'h2000, 16'h4000, 16'h4000};
    run_frame(0, 1'b0, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vout !== exp) begin errors++; $display("[TB] FAIL rounding_out got %h want %h", vout, exp); end
  endtask

  task automatic test_reset_midframe();
    int vseen, vcnt, vcyc, bbad;
    logic [63:0] vout;
    enable = 4'hF;
    in1 = {4{16'h4000}};
    in2 = {4{16'h4000}};
    @(negedge clk);
    lrclk = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) lrclk = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 64'h0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_reset got out=%h busy=%b valid=%b want 0/0/0", out, busy, valid);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    vseen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid === 1'b1) vseen++;
    end
    checks++;
    if (vseen !== 0) begin errors++; $display("[TB] FAIL midframe_no_valid got %0d want %0d", vseen, 0); end
    in2 = {16'h1000, 16'h2000, 16'h3000, 16'h4000};
    run_frame(0, 1'b0, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vcyc !== 11 || vout !== {16'h0800, 16'h1000, 16'h1800, 16'h2000}) begin
      errors++; $display("[TB] FAIL midframe_recover got cyc=%0d out=%h want cyc=11 out=%h",
                         vcyc, vout, {16'h0800, 16'h1000, 16'h1800, 16'h2000});
    end
  endtask

  task automatic test_overrun();
    int vcnt, vcyc, bbad;
    logic [63:0] vout;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_initial got %b want %b", overrun, 1'b0); end
    enable = 4'hF;
    in1 = {4{16'h4000}};
    in2 = {4{16'h2000}};
    // second edge lands in cycle 4; in2 changes after the snapshot was taken
    run_frame(4, 1'b1, 64'h0, vcnt, vcyc, bbad, vout);
    checks++;
    if (vcnt !== 1) begin errors++; $display("[TB] FAIL overrun_valid_count got %0d want %0d", vcnt, 1); end
    checks++;
    if (vout !== {4{16'h1000}}) begin
      errors++; $display("[TB] FAIL overrun_out got %h want %h", vout, {4{16'h1000}});
    end
    checks++;
    if (bbad !== 0) begin errors++; $display("[TB] FAIL overrun_busy_window got %0d want %0d", bbad, 0); end
    repeat (10) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky got %b want %b", overrun, 1'b1); end
    checks++;
    if (out !== {4{16'h1000}}) begin
      errors++; $display("[TB] FAIL overrun_hold got %h want %h", out, {4{16'h1000}});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear got %b want %b", overrun, 1'b0); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    lrclk  = 1'b0;
    enable = '0;
    in1    = '0;
    in2    = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_enable();
    test_rounding();
    test_reset_midframe();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
